// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
// Define WRR_LOCK_EN to add the lock signal.
interface wrr_arbiter_if #(
    parameter int N  = 4,
    parameter int WW = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
`ifdef WRR_LOCK_EN
    logic            lock;
`endif
    logic [N-1:0]    grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_valid;

    modport master (
        output req,
        output weight,
`ifdef WRR_LOCK_EN
        output lock,
`endif
        input  grant,
        input  grant_id,
        input  grant_valid
    );

    modport slave (
        input  req,
        input  weight,
`ifdef WRR_LOCK_EN
        input  lock,
`endif
        output grant,
        output grant_id,
        output grant_valid
    );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter, N requesters, burst of up to weight[i] cycles (WRR_LOCK_EN adds burst lock).
// Latency: req sampled at posedge, one-hot grant registered on the same edge.
// Backpressure: none; a requester drops req to release its grant early.
module wrr_arbiter #(
    parameter int N  = 4,
    parameter int WW = 4
) (
    input  logic          clk,
    input  logic          rst,
    wrr_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(N);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [WW-1:0]   credit_q, credit_d;

    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic [WW-1:0]   win_w;
    logic [WW-1:0]   win_credit;
    logic            lock_hold;

`ifdef WRR_LOCK_EN
    assign lock_hold = bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Search starts just past ptr; in OWN ptr is the owner, so it is visited last.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    assign win_w      = bus.weight[win_id*WW +: WW];
    assign win_credit = (win_w == '0) ? '0 : win_w - WW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= IDW'(N - 1);
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = OWN;
                    grant_d          = '0;
                    grant_d[win_id]  = 1'b1;
                    ptr_d            = win_id;
                    credit_d         = win_credit;
                end
            end
            OWN: begin
                if (bus.req[ptr_q] && lock_hold) begin
                    credit_d = credit_q;
                end else if (bus.req[ptr_q] && (credit_q != '0)) begin
                    credit_d = credit_q - WW'(1);
                end else if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_id]  = 1'b1;
                    ptr_d            = win_id;
                    credit_d         = win_credit;
                end else begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    credit_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;

    always_comb begin
        bus.grant_id = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) bus.grant_id = IDW'(i);
        end
    end
endmodule

// File: tb/tb_wrr_arbiter.sv
// Scoreboarded bench for wrr_arbiter (N=4, WW=4): directed plan sequences, then random traffic vs a model.
module tb_wrr_arbiter;
    localparam int N  = 4;
    localparam int WW = 4;
`ifdef WRR_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lock_v = 1'b0;

    wrr_arbiter_if #(.N(N), .WW(WW)) bus ();

    wrr_arbiter #(.N(N), .WW(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

`ifdef WRR_LOCK_EN
    assign bus.lock = lock_v;
`endif

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [N-1:0] expq[$];

    // Reference model: owner, cycles used in the current burst, budget captured at grant.
    int m_owner  = -1;
    int m_last   = N - 1;
    int m_used   = 0;
    int m_budget = 0;

    function automatic int enc(input logic [N-1:0] g);
        int r = 0;
        for (int i = 0; i < N; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic int pick(input logic [N-1:0] rq, input int from);
        for (int k = 0; k < N; k++) begin
            if (rq[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_used  = 0;
    endtask

    task automatic model_step(input logic [N-1:0] rq, input logic [N*WW-1:0] wt,
                              input logic lk, output logic [N-1:0] e);
        int w;
        int wv;
        bit lk_eff;
        lk_eff = LOCK_EN && lk;
        if (m_owner >= 0 && rq[m_owner] && (lk_eff || m_used < m_budget)) begin
            if (!lk_eff) m_used++;
        end else begin
            w = pick(rq, ((m_owner >= 0) ? m_owner : m_last) + 1);
            if (w >= 0) begin
                wv       = int'(wt[w*WW +: WW]);
                m_owner  = w;
                m_last   = w;
                m_budget = (wv < 1) ? 1 : wv;
                m_used   = 1;
            end else begin
                m_owner = -1;
            end
        end
        e = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    endtask

    // Drive one cycle at the negedge; push what the following posedge must produce.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*WW-1:0] wt,
                        input logic lk, input bit use_model, input logic [N-1:0] exp_g);
        logic [N-1:0] e;
        @(negedge clk);
        rst        = r;
        bus.req    = rq;
        bus.weight = wt;
        lock_v     = lk;
        if (r) begin
            model_reset();
            e = '0;
        end else if (use_model) begin
            model_step(rq, wt, lk, e);
        end else begin
            e = exp_g;
        end
        expq.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: compare the registered outputs against the scoreboard every cycle.
    logic [N-1:0] mon_e;
    bit           mon_ok;
    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            mon_e  = expq.pop_front();
            checks++;
            mon_ok = (bus.grant === mon_e) && (bus.grant_valid === (|mon_e)) &&
                     (!(|mon_e) || (int'(bus.grant_id) == enc(mon_e)));
            if (!mon_ok) begin
                failures++;
                $display("FAIL grant t=%0t got grant=%b id=%0d vld=%b want grant=%b id=%0d vld=%b",
                         $time, bus.grant, bus.grant_id, bus.grant_valid, mon_e, enc(mon_e), |mon_e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_a[5];
        logic [3:0] exp_b[7];
        bus.req    = '0;
        bus.weight = '0;

        // Reset held with requests pending, then equal-weight rotation.
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 16'h1111, 1'b0, 1'b0, 4'b0000);
        exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, 16'h1111, 1'b0, 1'b0, exp_a[i]);

        // weight[3]=3.
        step(1'b1, 4'b0000, 16'h3111, 1'b0, 1'b0, 4'b0000);
        exp_b = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
        for (int i = 0; i < 7; i++) step(1'b0, 4'b1111, 16'h3111, 1'b0, 1'b0, exp_b[i]);

        // Early release of a weight-4 burst, then weight 0 lone requester.
        step(1'b1, 4'b0000, 16'h1114, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 4'b0001, 16'h1114, 1'b0, 1'b0, 4'b0001);
        step(1'b0, 4'b0001, 16'h1114, 1'b0, 1'b0, 4'b0001);
        step(1'b0, 4'b0100, 16'h1114, 1'b0, 1'b0, 4'b0100);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0100, 16'h1011, 1'b0, 1'b0, 4'b0100);

        // Sparse requests after a grant to 1.
        step(1'b1, 4'b0000, 16'h1111, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 4'b0010, 16'h1111, 1'b0, 1'b0, 4'b0010);
        step(1'b0, 4'b1010, 16'h1111, 1'b0, 1'b0, 4'b1000);
        step(1'b0, 4'b1010, 16'h1111, 1'b0, 1'b0, 4'b0010);

        // Reset in the middle of a long burst clears the grant without a clock.
        step(1'b1, 4'b0000, 16'h11F1, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 4'b0010, 16'h11F1, 1'b0, 1'b0, 4'b0010);
        step(1'b0, 4'b1010, 16'h11F1, 1'b0, 1'b0, 4'b0010);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_rst got grant=%b vld=%b want grant=0000 vld=0", bus.grant, bus.grant_valid);
        end
        step(1'b1, 4'b1010, 16'h11F1, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 4'b1010, 16'h11F1, 1'b0, 1'b0, 4'b0010);

        if (LOCK_EN) begin
            step(1'b1, 4'b0000, 16'h1111, 1'b0, 1'b0, 4'b0000);
            step(1'b0, 4'b0010, 16'h1111, 1'b1, 1'b0, 4'b0010);
            for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 16'h1111, 1'b1, 1'b0, 4'b0010);
            step(1'b0, 4'b1111, 16'h1111, 1'b0, 1'b0, 4'b0100);
        end

        // Random traffic against the model.
        begin
            logic [N-1:0]    rq;
            logic [N*WW-1:0] wt;
            logic            lk;
            wt = 16'h1111;
            step(1'b1, 4'b0000, wt, 1'b0, 1'b1, 4'b0000);
            for (int c = 0; c < 3000; c++) begin
                for (int b = 0; b < N; b++) rq[b] = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 3) == 0) wt = 16'($urandom);
                lk = ($urandom_range(0, 7) == 0);
                step(($urandom_range(0, 299) == 0), rq, wt, lk, 1'b1, 4'b0000);
            end
        end

        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want pending=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
